// File: rtl/lsu_align_unit_if.sv
// Request/memory/response bundle for the load/store alignment unit.
// The slave modport is the unit's view; master is the environment's view.
interface lsu_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int B = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [B-1:0]      mem_we;
    logic [XLEN-1:0]   mem_din;
    logic [XLEN-1:0]   mem_dout;
    logic              mem_stall;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_fault;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout, mem_stall,
        output req_ready, mem_addr, mem_re, mem_we, mem_din, rsp_valid, rsp_rdata, rsp_fault, busy
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout, mem_stall,
        input  req_ready, mem_addr, mem_re, mem_we, mem_din, rsp_valid, rsp_rdata, rsp_fault, busy
    );
endinterface

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: splits word-crossing accesses into two beats,
// positions store lanes, merges and extends load data, reports faults.
module lsu_align_unit #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    lsu_align_unit_if.slave    bus
);
    localparam int B     = XLEN / 8;
    localparam int B2    = 2 * B;
    localparam int OFF_W = $clog2(B);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_RESP, S_FAULT} state_t;

    state_t            r_state, w_next;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_cross;
    logic [XLEN-1:0]   r_beat0;
    logic              r_rsp_valid;
    logic              r_rsp_fault;
    logic [XLEN-1:0]   r_rsp_rdata;

    logic              w_accept;
    logic [4:0]        w_req_size;
    logic              w_req_cross;
    logic              w_req_illegal;
    logic              w_req_fault;
    logic [OFF_W-1:0]  w_off;
    logic [OFF_W+2:0]  w_shamt;
    logic [4:0]        w_size;
    logic [B2-1:0]     w_mask2;
    logic [2*XLEN-1:0] w_data2;
    logic [ADDR_W-1:0] w_word;
    logic [B-1:0]      w_lanes;
    logic [XLEN-1:0]   w_dhalf;
    logic [XLEN-1:0]   w_merged;

    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        logic signed [31:0] s32;
        s8  = d[7:0];
        s16 = d[15:0];
        s32 = d[31:0];
        case (f3)
            3'd0:    extend = XLEN'(s8);
            3'd1:    extend = XLEN'(s16);
            3'd2:    extend = XLEN'(s32);
            3'd4:    extend = XLEN'(d[7:0]);
            3'd5:    extend = XLEN'(d[15:0]);
            3'd6:    extend = XLEN'(d[31:0]);
            default: extend = d;
        endcase
    endfunction

    // Request classification, evaluated on the live request bus
    assign w_accept      = bus.req_valid && (r_state == S_IDLE);
    assign w_req_size    = 5'd1 << bus.req_funct3[1:0];
    assign w_req_cross   = (5'(bus.req_addr[OFF_W-1:0]) + w_req_size) > 5'(B);
    assign w_req_illegal = (bus.req_funct3 == 3'd7) ||
                           ((XLEN == 32) && (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6));
    assign w_req_fault   = w_req_illegal || (w_req_cross && (SPLIT_EN == 0));

    assign w_off    = r_addr[OFF_W-1:0];
    assign w_shamt  = {w_off, 3'b000};
    assign w_size   = 5'd1 << r_funct3[1:0];
    assign w_mask2  = ((B2'(1) << w_size) - B2'(1)) << w_off;
    assign w_data2  = {XLEN'(0), r_wdata} << w_shamt;
    assign w_word   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_lanes  = (r_state == S_ISSUE1) ? w_mask2[B2-1:B] : w_mask2[B-1:0];
    assign w_dhalf  = (r_state == S_ISSUE1) ? w_data2[2*XLEN-1:XLEN] : w_data2[XLEN-1:0];
    // In RESP, mem_dout holds the last beat; beat 0 was captured earlier for split loads
    assign w_merged = XLEN'({(r_cross ? bus.mem_dout : XLEN'(0)),
                             (r_cross ? r_beat0 : bus.mem_dout)} >> w_shamt);

    always_comb begin
        w_next       = r_state;
        bus.mem_addr = '0;
        bus.mem_re   = 1'b0;
        bus.mem_we   = '0;
        bus.mem_din  = '0;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_req_fault ? S_FAULT : S_ISSUE0;
            S_ISSUE0, S_ISSUE1: begin
                bus.mem_addr = (r_state == S_ISSUE1) ? w_word + ADDR_W'(B) : w_word;
                bus.mem_re   = !r_we;
                if (r_we) begin
                    bus.mem_we = w_lanes;
                    for (int i = 0; i < B; i++)
                        bus.mem_din[8*i +: 8] = w_lanes[i] ? w_dhalf[8*i +: 8] : 8'h00;
                end
                if (!bus.mem_stall)
                    w_next = (r_state == S_ISSUE0 && r_cross) ? S_ISSUE1 : S_RESP;
            end
            S_RESP:   if (!bus.mem_stall) w_next = S_IDLE;
            S_FAULT:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cross     <= 1'b0;
            r_beat0     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_cross  <= w_req_cross;
            end
            if (r_state == S_ISSUE1 && !bus.mem_stall)
                r_beat0 <= bus.mem_dout;
            if (r_state == S_RESP && !bus.mem_stall) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_we ? XLEN'(0) : extend(r_funct3, w_merged);
            end
            if (r_state == S_FAULT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_fault <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: XLEN=32 split-enabled unit plus a
// SPLIT_EN=0 unit for misaligned-fault behaviour.
module tb_lsu_align_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] mem [0:1023];

    lsu_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus1();
    lsu_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus2();

    lsu_align_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_EN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave));
    lsu_align_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_EN(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    always #5 clk = ~clk;

    // Synchronous-read memory for the split-enabled unit
    always @(posedge clk)
        if (bus1.mem_re && !bus1.mem_stall) bus1.mem_dout <= mem[bus1.mem_addr[11:2]];

    task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (!sel) begin
            bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_funct3 = f3;
            bus1.req_addr = a; bus1.req_wdata = d;
        end else begin
            bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_funct3 = f3;
            bus2.req_addr = a; bus2.req_wdata = d;
        end
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        bus2.req_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", bus1.req_ready); end
        n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus1.busy); end
        n_checks++; if ({bus1.rsp_valid, bus1.rsp_fault, bus1.mem_re, bus1.mem_we} !== 7'b0) begin
            n_fail++; $display("FAIL rst_strobes got=%b exp=0", {bus1.rsp_valid, bus1.rsp_fault, bus1.mem_re, bus1.mem_we}); end
        n_checks++; if ({bus1.rsp_rdata, bus1.mem_addr, bus1.mem_din} !== 96'h0) begin
            n_fail++; $display("FAIL rst_data got=%h exp=0", {bus1.rsp_rdata, bus1.mem_addr, bus1.mem_din}); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw_aligned;
        mem[10'h040] = 32'hDEADBEEF;
        issue(0, 1'b0, 3'd2, 32'h100, 32'h0);
        @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got=%h exp=%h", bus1.mem_addr, 32'h100); end
        n_checks++; if (bus1.mem_re !== 1'b1 || bus1.mem_we !== 4'b0) begin n_fail++; $display("FAIL lw_strobe got re=%b we=%b exp re=1 we=0", bus1.mem_re, bus1.mem_we); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b0 || bus1.mem_re !== 1'b0) begin n_fail++; $display("FAIL lw_t2 got rsp=%b re=%b exp 0 0", bus1.rsp_valid, bus1.mem_re); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lw_rsp_valid got=%b exp=1", bus1.rsp_valid); end
        n_checks++; if (bus1.rsp_rdata !== 32'hDEADBEEF || bus1.rsp_fault !== 1'b0) begin
            n_fail++; $display("FAIL lw_rdata got=%h/%b exp=deadbeef/0", bus1.rsp_rdata, bus1.rsp_fault); end
    endtask

    task automatic test_lh_split;
        mem[10'h040] = 32'h11223344;
        mem[10'h041] = 32'h55667788;
        issue(0, 1'b0, 3'd1, 32'h103, 32'h0);
        @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h100 || bus1.mem_re !== 1'b1) begin n_fail++; $display("FAIL lh_beat0 got=%h/%b exp=100/1", bus1.mem_addr, bus1.mem_re); end
        @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h104 || bus1.mem_re !== 1'b1) begin n_fail++; $display("FAIL lh_beat1 got=%h/%b exp=104/1", bus1.mem_addr, bus1.mem_re); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lh_early got=%b exp=0", bus1.rsp_valid); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'hFFFF8811) begin
            n_fail++; $display("FAIL lh_rdata got=%b/%h exp=1/ffff8811", bus1.rsp_valid, bus1.rsp_rdata); end
        issue(0, 1'b0, 3'd5, 32'h103, 32'h0);
        repeat (4) @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'h00008811) begin
            n_fail++; $display("FAIL lhu_rdata got=%b/%h exp=1/00008811", bus1.rsp_valid, bus1.rsp_rdata); end
    endtask

    task automatic test_sw_split;
        issue(0, 1'b1, 3'd2, 32'h102, 32'hAABBCCDD);
        @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h100 || bus1.mem_we !== 4'b1100 || bus1.mem_din !== 32'hCCDD0000 || bus1.mem_re !== 1'b0) begin
            n_fail++; $display("FAIL sw_beat0 got addr=%h we=%b din=%h re=%b exp 100/1100/ccdd0000/0", bus1.mem_addr, bus1.mem_we, bus1.mem_din, bus1.mem_re); end
        @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h104 || bus1.mem_we !== 4'b0011 || bus1.mem_din !== 32'h0000AABB) begin
            n_fail++; $display("FAIL sw_beat1 got addr=%h we=%b din=%h exp 104/0011/0000aabb", bus1.mem_addr, bus1.mem_we, bus1.mem_din); end
        @(negedge clk);
        n_checks++; if (bus1.mem_we !== 4'b0 || bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_t3 got we=%b rsp=%b exp 0/0", bus1.mem_we, bus1.rsp_valid); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'h0 || bus1.rsp_fault !== 1'b0) begin
            n_fail++; $display("FAIL sw_rsp got=%b/%h/%b exp=1/0/0", bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_fault); end
    endtask

    task automatic test_sb;
        issue(0, 1'b1, 3'd0, 32'h201, 32'h1234565A);
        @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h200 || bus1.mem_we !== 4'b0010 || bus1.mem_din !== 32'h00005A00) begin
            n_fail++; $display("FAIL sb_beat got addr=%h we=%b din=%h exp 200/0010/00005a00", bus1.mem_addr, bus1.mem_we, bus1.mem_din); end
        @(negedge clk);
        n_checks++; if (bus1.mem_we !== 4'b0) begin n_fail++; $display("FAIL sb_single got we=%b exp=0", bus1.mem_we); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sb_rsp got=%b/%h exp=1/0", bus1.rsp_valid, bus1.rsp_rdata); end
    endtask

    task automatic test_stall;
        mem[10'h040] = 32'hCAFEF00D;
        issue(0, 1'b0, 3'd2, 32'h100, 32'h0);
        bus1.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus1.mem_addr !== 32'h100 || bus1.mem_re !== 1'b1 || bus1.rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d got addr=%h re=%b rsp=%b exp 100/1/0", i, bus1.mem_addr, bus1.mem_re, bus1.rsp_valid); end
        end
        @(posedge clk); #1;
        bus1.mem_stall = 1'b0;
        @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h100 || bus1.mem_re !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%h/%b exp=100/1", bus1.mem_addr, bus1.mem_re); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early got=%b exp=0", bus1.rsp_valid); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL stall_rsp got=%b/%h exp=1/cafef00d", bus1.rsp_valid, bus1.rsp_rdata); end
    endtask

    task automatic test_fault;
        issue(1, 1'b0, 3'd2, 32'h101, 32'h0);
        @(negedge clk);
        n_checks++; if (bus2.mem_re !== 1'b0 || bus2.mem_we !== 4'b0 || bus2.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mis_t1 got re=%b we=%b rsp=%b exp 0/0/0", bus2.mem_re, bus2.mem_we, bus2.rsp_valid); end
        @(negedge clk);
        n_checks++; if (bus2.rsp_valid !== 1'b1 || bus2.rsp_fault !== 1'b1 || bus2.rsp_rdata !== 32'h0 || bus2.mem_re !== 1'b0) begin
            n_fail++; $display("FAIL mis_rsp got=%b/%b/%h/%b exp=1/1/0/0", bus2.rsp_valid, bus2.rsp_fault, bus2.rsp_rdata, bus2.mem_re); end
        issue(0, 1'b0, 3'd3, 32'h100, 32'h0);
        @(negedge clk);
        n_checks++; if (bus1.mem_re !== 1'b0 || bus1.mem_we !== 4'b0) begin n_fail++; $display("FAIL ill_strobe got re=%b we=%b exp 0/0", bus1.mem_re, bus1.mem_we); end
        @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_fault !== 1'b1) begin n_fail++; $display("FAIL ill_rsp got=%b/%b exp=1/1", bus1.rsp_valid, bus1.rsp_fault); end
    endtask

    task automatic test_back_to_back;
        mem[10'h040] = 32'h0BADF00D;
        mem[10'h041] = 32'h55667788;
        issue(0, 1'b0, 3'd2, 32'h100, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.req_ready !== 1'b1 || bus1.rsp_rdata !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL b2b_first got=%b/%b/%h exp=1/1/0badf00d", bus1.rsp_valid, bus1.req_ready, bus1.rsp_rdata); end
        issue(0, 1'b0, 3'd2, 32'h104, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'h55667788) begin
            n_fail++; $display("FAIL b2b_second got=%b/%h exp=1/55667788", bus1.rsp_valid, bus1.rsp_rdata); end
    endtask

    task automatic test_reset_midflight;
        mem[10'h040] = 32'h11223344;
        mem[10'h041] = 32'h55667788;
        issue(0, 1'b0, 3'd1, 32'h103, 32'h0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus1.mem_addr !== 32'h104 || bus1.busy !== 1'b1) begin n_fail++; $display("FAIL mid_issue1 got=%h/%b exp=104/1", bus1.mem_addr, bus1.busy); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus1.req_ready !== 1'b1 || bus1.mem_re !== 1'b0) begin n_fail++; $display("FAIL mid_async got ready=%b re=%b exp 1/0", bus1.req_ready, bus1.mem_re); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin
                n_fail++; $display("FAIL mid_quiet%0d got rsp=%b ready=%b exp 0/1", i, bus1.rsp_valid, bus1.req_ready); end
        end
        mem[10'h040] = 32'hDEADBEEF;
        issue(0, 1'b0, 3'd2, 32'h100, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL mid_next got=%b/%h exp=1/deadbeef", bus1.rsp_valid, bus1.rsp_rdata); end
    endtask

    initial begin
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'd0;
        bus1.req_addr = '0; bus1.req_wdata = '0; bus1.mem_stall = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = 3'd0;
        bus2.req_addr = '0; bus2.req_wdata = '0; bus2.mem_stall = 1'b0;
        bus2.mem_dout = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_lw_aligned();
        test_lh_split();
        test_sw_split();
        test_sb();
        test_stall();
        test_fault();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
Parametrised load/store alignment unit between the execute stage and the data cache. It accepts one load or store per handshake and drives byte lanes and word-aligned addresses to a synchronous-read data memory. Misaligned accesses are either split into two word beats and merged, or reported as faults. Loads are sign- or zero-extended before return; every request gets exactly one response pulse.

Parameters:
XLEN, 32, data width in bits, 32 or 64; B = XLEN/8 bytes per word.
ADDR_W, 32, address width.
SPLIT_EN, 1, 1 = split word-crossing accesses into two beats; 0 = fault on them.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept (state IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  size: 0 B, 1 H, 2 W, 3 D (XLEN=64 only), 4 BU, 5 HU, 6 WU (XLEN=64 only)
req_addr  input  ADDR_W  byte address
req_wdata  input  XLEN  store data, right-justified
mem_addr  output  ADDR_W  word-aligned address, low log2(B) bits zero
mem_re  output  1  read strobe
mem_we  output  B  byte-lane write enables
mem_din  output  XLEN  lane-positioned write data
mem_dout  input  XLEN  read data, valid one cycle after the address is accepted
mem_stall  input  1  memory not accepting; everything freezes
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  XLEN  extended load data; 0 for stores and faults
rsp_fault  output  1  qualifies rsp_valid: illegal size or misaligned with SPLIT_EN=0
busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous): state IDLE; rsp_valid, rsp_fault, mem_re = 0; mem_we = 0; rsp_rdata, mem_addr, mem_din = 0. An in-flight transaction is abandoned with no response.
- Handshake: a request is accepted when req_valid and req_ready are both 1. All request fields are registered on acceptance. req_ready = (state == IDLE).
- Derived values: off = addr[log2(B)-1:0]; size = 1, 2, 4 or 8 bytes; cross = (off + size > B).
- Illegal funct3 values are 7, and 3 or 6 when XLEN=32.
- Fault: an illegal funct3, or cross with SPLIT_EN=0.
  - Accept goes to FAULT, then IDLE.
  - rsp_valid=1 and rsp_fault=1 in the cycle after FAULT.
  - No mem_re or mem_we is ever driven for a faulting request.
- States: IDLE, ISSUE0, ISSUE1, RESP, FAULT.
  - IDLE → ISSUE0 on accept.
  - ISSUE0: drive beat 0, mem_addr = word(addr). Go to ISSUE1 if cross, else RESP.
  - ISSUE1: capture mem_dout as beat0. Drive beat 1, mem_addr = word(addr) + B. Go to RESP.
  - RESP: merge and extend the data, register rsp_*, go to IDLE.
- Latency (accept at cycle T, no stall): rsp_valid at T+3 for a single-beat access, T+4 for a split access.
- rsp_valid may coincide with acceptance of the next request.
- Stall: while mem_stall=1 in ISSUE0, ISSUE1 or RESP:
  - state, captured data and all mem_* outputs are held;
  - the memory treats the held request as not yet accepted.
  - mem_stall is ignored in IDLE and FAULT.
- Loads:
  - mem_re = 1 only in ISSUE states; mem_we = 0.
  - Merge: {beat1, beat0} (beat1 = 0 if not split) shifted right by off*8.
  - Extend by funct3: B/H/W sign-extend; BU/HU/WU zero-extend; D passes through.
- Stores:
  - mem_re = 0. The mask has size ones shifted left by off, across a 2B-lane window.
  - Beat 0 uses the low B bits of the mask. Beat 1 uses the high B bits.
  - Store data is shifted left by off*8 across a 2*XLEN window, low/high halves to beats 0/1.
  - Unused lanes of mem_din are driven 0.
  - Response is rsp_valid=1, rsp_rdata=0, rsp_fault=0.
- Aligned W/D accesses never split. Address wrap: word(addr) + B wraps modulo 2^ADDR_W.

Test Plan:
- XLEN=32. LW at 0x100, mem[0x100]=0xDEADBEEF → one beat: mem_re=1, mem_addr=0x100 at T+1; rsp_valid at T+3 with rdata 0xDEADBEEF, fault 0.
- XLEN=32. LH at 0x103, mem[0x100]=0x11223344, mem[0x104]=0x55667788 → beats at 0x100 (T+1) and 0x104 (T+2); rsp at T+4 with rdata 0xFFFF8811. LHU returns 0x00008811.
- XLEN=32. SW at 0x102, data 0xAABBCCDD → beat 0: addr 0x100, we 4'b1100, din 0xCCDD0000. Beat 1: addr 0x104, we 4'b0011, din 0x0000AABB. rsp_valid at T+4.
- XLEN=32. SB at 0x201, data 0x5A → single beat: addr 0x200, we 4'b0010, din 0x00005A00.
- mem_stall held high 3 cycles starting in ISSUE0 of an aligned LW → mem_addr and mem_re are stable throughout; rsp_valid at T+6 with correct data.
- SPLIT_EN=0, LW at 0x101 → rsp_valid=1 and rsp_fault=1 at T+2, no memory strobes. Separately: reset_n low during ISSUE1 of a split access → no rsp_valid, req_ready=1 after release, next request completes normally.
